// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory.
// Misaligned accesses that straddle a word boundary become two word accesses.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | access to the word holding the first byte
// ACC1  | access to the following word (split accesses only)
// RESP  | one-cycle completion pulse
// ERR   | one-cycle completion pulse for an illegal funct3
module load_store_unit #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wmask,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_RESP,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rd0_q, rd0_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wd_q, mem_wd_d;

    logic          req_legal;
    logic [1:0]    off;
    logic [3:0]    size_mask;
    logic [7:0]    be8;
    logic          split;
    logic [AW-1:0] lo_addr;
    logic [AW-1:0] hi_addr;
    logic [4:0]    sh_lo;
    logic [5:0]    sh_hi;
    logic [31:0]   rd_lo;
    logic [23:0]   rd_hi;
    logic [31:0]   load_raw;
    logic [31:0]   load_ext;
    logic [31:0]   done_rdata;
    logic [3:0]    wmask_raw;

    // Stores only have byte/half/word; loads add the unsigned byte/half forms.
    always_comb begin
        if (req_we) begin
            req_legal = (req_funct3 <= 3'd2);
        end else begin
            req_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) &&
                        (req_funct3 != 3'b111);
        end
    end

    always_comb begin
        off = addr_q[1:0];
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        be8     = {4'b0000, size_mask} << off;
        split   = |be8[7:4];
        lo_addr = {addr_q[AW-1:2], 2'b00};
        hi_addr = lo_addr + AW'(4);
        sh_lo   = {off, 3'b000};
        sh_hi   = 6'd32 - {1'b0, off, 3'b000};
    end

    // In ACC1 the low word comes from the ACC0 capture and the high word is live.
    always_comb begin
        if (state_q == S_ACC1) begin
            rd_lo = rd0_q;
            rd_hi = mem_rd[23:0];
        end else begin
            rd_lo = mem_rd;
            rd_hi = 24'h000000;
        end
        case (off)
            2'd0:    load_raw = rd_lo;
            2'd1:    load_raw = {rd_hi[7:0],  rd_lo[31:8]};
            2'd2:    load_raw = {rd_hi[15:0], rd_lo[31:16]};
            default: load_raw = {rd_hi[23:0], rd_lo[31:24]};
        endcase
        case (funct3_q)
            3'b000:  load_ext = {{24{load_raw[7]}}, load_raw[7:0]};
            3'b001:  load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
            3'b100:  load_ext = {24'h000000, load_raw[7:0]};
            3'b101:  load_ext = {16'h0000, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
        done_rdata = we_q ? 32'h0000_0000 : load_ext;
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd0_d        = rd0_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        wmask_raw    = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_legal) begin
                        state_d = S_ACC0;
                    end else begin
                        state_d      = S_ERR;
                        resp_rdata_d = 32'h0000_0000;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            S_ACC0: begin
                mem_addr_d = lo_addr;
                mem_wd_d   = wdata_q << sh_lo;
                wmask_raw  = we_q ? be8[3:0] : 4'b0000;
                rd0_d      = mem_rd;
                if (split) begin
                    state_d = S_ACC1;
                end else begin
                    state_d      = S_RESP;
                    resp_rdata_d = done_rdata;
                    resp_err_d   = 1'b0;
                end
            end
            S_ACC1: begin
                mem_addr_d   = hi_addr;
                mem_wd_d     = wdata_q >> sh_hi;
                wmask_raw    = we_q ? be8[7:4] : 4'b0000;
                state_d      = S_RESP;
                resp_rdata_d = done_rdata;
                resp_err_d   = 1'b0;
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            rd0_q        <= 32'h0000_0000;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wd_q     <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd0_q        <= rd0_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
        end
    end

    // Address/data are live in the access states and hold their last value elsewhere.
    assign mem_addr   = mem_addr_d;
    assign mem_wd     = mem_wd_d;
    assign mem_wmask  = reset ? 4'b0000 : wmask_raw;
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = !reset && ((state_q == S_RESP) || (state_q == S_ERR));
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-maskable word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    logic [31:0] mem [0:255];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    load_store_unit #(.AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in the current (IDLE) cycle and advances to cycle 1.
    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input int lat, input logic [31:0] exp);
        issue(tag, 1'b0, f3, addr, 32'h0);
        for (int c = 1; c <= lat; c++) begin
            chk({tag, "_wmask"}, 32'(mem_wmask), 32'd0);
            chk({tag, "_valid"}, 32'(resp_valid), (c == lat) ? 32'd1 : 32'd0);
            if (c == lat) begin
                chk({tag, "_rdata"}, resp_rdata, exp);
                chk({tag, "_err"}, 32'(resp_err), 32'd0);
            end
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        pl_en      = 1'b0;
        pl_idx     = 8'h00;
        pl_data    = 32'h0;
        step();
        step();

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_wd", mem_wd, 32'h0);

        pl_en = 1'b1;
        pl_idx = 8'h40; pl_data = 32'h4433_2211; step();
        pl_idx = 8'h41; pl_data = 32'h8877_6655; step();
        pl_idx = 8'hFF; pl_data = 32'hA1B2_C3D4; step();
        pl_idx = 8'h00; pl_data = 32'h1122_3344; step();
        pl_en = 1'b0;
        reset = 1'b0;

        // Aligned word load
        issue("lw100", 1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw100_addr", mem_addr, 32'h100);
        chk("lw100_wmask1", 32'(mem_wmask), 32'd0);
        chk("lw100_valid1", 32'(resp_valid), 32'd0);
        step();
        chk("lw100_valid2", 32'(resp_valid), 32'd1);
        chk("lw100_rdata", resp_rdata, 32'h4433_2211);
        chk("lw100_wmask2", 32'(mem_wmask), 32'd0);
        step();
        chk("lw100_idle", 32'(req_ready), 32'd1);
        chk("lw100_valid3", 32'(resp_valid), 32'd0);
        chk("lw100_hold", resp_rdata, 32'h4433_2211);

        load_chk("lb103", 3'b000, 32'h103, 2, 32'h0000_0044);
        load_chk("lb107", 3'b000, 32'h107, 2, 32'hFFFF_FF88);
        load_chk("lbu107", 3'b100, 32'h107, 2, 32'h0000_0088);
        load_chk("lh106", 3'b001, 32'h106, 2, 32'hFFFF_8877);
        load_chk("lhu106", 3'b101, 32'h106, 2, 32'h0000_8877);

        // Split word load
        issue("lw102", 1'b0, 3'b010, 32'h102, 32'h0);
        chk("lw102_addr0", mem_addr, 32'h100);
        chk("lw102_ready1", 32'(req_ready), 32'd0);
        chk("lw102_valid1", 32'(resp_valid), 32'd0);
        step();
        chk("lw102_addr1", mem_addr, 32'h104);
        chk("lw102_ready2", 32'(req_ready), 32'd0);
        chk("lw102_valid2", 32'(resp_valid), 32'd0);
        step();
        chk("lw102_ready3", 32'(req_ready), 32'd0);
        chk("lw102_valid3", 32'(resp_valid), 32'd1);
        chk("lw102_rdata", resp_rdata, 32'h6655_4433);
        step();
        chk("lw102_idle", 32'(req_ready), 32'd1);

        // Split halfword store
        issue("sh103", 1'b1, 3'b001, 32'h103, 32'h0000_BEEF);
        chk("sh103_addr0", mem_addr, 32'h100);
        chk("sh103_mask0", 32'(mem_wmask), 32'h8);
        chk("sh103_wd0", 32'(mem_wd[31:24]), 32'hEF);
        step();
        chk("sh103_addr1", mem_addr, 32'h104);
        chk("sh103_mask1", 32'(mem_wmask), 32'h1);
        chk("sh103_wd1", 32'(mem_wd[7:0]), 32'hBE);
        step();
        chk("sh103_valid", 32'(resp_valid), 32'd1);
        chk("sh103_rdata", resp_rdata, 32'h0);
        chk("sh103_err", 32'(resp_err), 32'd0);
        step();
        load_chk("rb100a", 3'b010, 32'h100, 2, 32'hEF33_2211);
        load_chk("rb104a", 3'b010, 32'h104, 2, 32'h8877_66BE);

        // Illegal load funct3
        issue("ill", 1'b0, 3'b011, 32'h100, 32'h0);
        chk("ill_valid", 32'(resp_valid), 32'd1);
        chk("ill_err", 32'(resp_err), 32'd1);
        chk("ill_rdata", resp_rdata, 32'h0);
        chk("ill_wmask", 32'(mem_wmask), 32'd0);
        step();
        chk("ill_idle", 32'(req_ready), 32'd1);
        chk("ill_valid2", 32'(resp_valid), 32'd0);
        chk("ill_errhold", 32'(resp_err), 32'd1);

        // Illegal store funct3 must not write
        issue("ills", 1'b1, 3'b011, 32'h100, 32'hFFFF_FFFF);
        chk("ills_valid", 32'(resp_valid), 32'd1);
        chk("ills_err", 32'(resp_err), 32'd1);
        chk("ills_wmask", 32'(mem_wmask), 32'd0);
        step();

        // Split word store interrupted by reset in its second access
        issue("sw102", 1'b1, 3'b010, 32'h102, 32'hDEAD_BEEF);
        chk("sw102_mask0", 32'(mem_wmask), 32'hC);
        chk("sw102_wd0", mem_wd, 32'hBEEF_0000);
        step();
        chk("sw102_addr1", mem_addr, 32'h104);
        chk("sw102_mask1", 32'(mem_wmask), 32'h3);
        reset = 1'b1;
        #1;
        chk("sw102_rstmask", 32'(mem_wmask), 32'd0);
        step();
        reset = 1'b0;
        chk("sw102_ready", 32'(req_ready), 32'd1);
        chk("sw102_valid", 32'(resp_valid), 32'd0);
        step();
        chk("sw102_valid2", 32'(resp_valid), 32'd0);
        load_chk("rb100b", 3'b010, 32'h100, 2, 32'hBEEF_2211);
        // 0x104 keeps the value left by the halfword store above
        load_chk("rb104b", 3'b010, 32'h104, 2, 32'h8877_66BE);

        // Address wrap on the second access
        issue("wrap", 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr1", mem_addr, 32'h0000_0000);
        step();
        chk("wrap_valid", 32'(resp_valid), 32'd1);
        chk("wrap_rdata", resp_rdata, 32'h3344_A1B2);
        step();
        chk("wrap_idle", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
